// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready stream bundle for the pipelined barrel shifter: operand beat in, result beat out.
// The master side produces operands and consumes results; the slave side is the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit, all stages advance
// together under a single enable, with carry-out and zero flags on the result.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    ModeLsl = 2'b00,
    ModeLsr = 2'b01,
    ModeAsr = 2'b10,
    ModeRor = 2'b11
  } mode_e;

  localparam int unsigned Last = SHAMT_W - 1;

  logic adv;

  // Stage inputs: stage 0 takes the bus, stage k takes the registers of stage k-1.
  logic [WIDTH-1:0]   st_data  [SHAMT_W];
  logic [SHAMT_W-1:0] st_shamt [SHAMT_W];
  mode_e              st_mode  [SHAMT_W];
  logic               st_carry [SHAMT_W];
  logic               st_valid [SHAMT_W];

  logic [WIDTH-1:0]   data_d   [SHAMT_W];
  logic               carry_d  [SHAMT_W];
  logic [WIDTH-1:0]   spill;

  logic [WIDTH-1:0]   data_q   [SHAMT_W];
  logic               carry_q  [SHAMT_W];
  logic               valid_q  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q  [SHAMT_W-1];
  mode_e              mode_q   [SHAMT_W-1];
  logic               zero_q;

  assign adv = !valid_q[Last] || bus.out_ready;

  always_comb begin
    st_data[0]  = bus.in_data;
    st_shamt[0] = bus.in_shamt;
    st_mode[0]  = mode_e'(bus.in_mode);
    st_carry[0] = 1'b0;
    st_valid[0] = bus.in_valid;
    for (int k = 1; k < SHAMT_W; k++) begin
      st_data[k]  = data_q[k-1];
      st_shamt[k] = shamt_q[k-1];
      st_mode[k]  = mode_q[k-1];
      st_carry[k] = carry_q[k-1];
      st_valid[k] = valid_q[k-1];
    end
  end

  // Stage k shifts by 2^k; carry is the last bit pushed out, which for ROR is the new MSB.
  always_comb begin
    spill = '0;
    for (int k = 0; k < SHAMT_W; k++) begin
      data_d[k]  = st_data[k];
      carry_d[k] = st_carry[k];
      if (st_shamt[k][k]) begin
        unique case (st_mode[k])
          ModeLsl: begin
            data_d[k]  = st_data[k] << (1 << k);
            spill      = st_data[k] >> (WIDTH - (1 << k));
            carry_d[k] = spill[0];
          end
          ModeLsr: begin
            data_d[k]  = st_data[k] >> (1 << k);
            spill      = st_data[k] >> ((1 << k) - 1);
            carry_d[k] = spill[0];
          end
          ModeAsr: begin
            data_d[k]  = $unsigned($signed(st_data[k]) >>> (1 << k));
            spill      = st_data[k] >> ((1 << k) - 1);
            carry_d[k] = spill[0];
          end
          ModeRor: begin
            data_d[k]  = (st_data[k] >> (1 << k)) | (st_data[k] << (WIDTH - (1 << k)));
            spill      = st_data[k] >> ((1 << k) - 1);
            carry_d[k] = spill[0];
          end
          default: begin
            data_d[k]  = st_data[k];
            carry_d[k] = st_carry[k];
          end
        endcase
      end
    end
  end

  // Bubbles carry zero data so idle outputs read 0 and never leak stale operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
      end
      for (int k = 0; k < SHAMT_W - 1; k++) begin
        shamt_q[k] <= '0;
        mode_q[k]  <= ModeLsl;
      end
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= st_valid[k] ? data_d[k] : '0;
        carry_q[k] <= st_valid[k] && carry_d[k];
        valid_q[k] <= st_valid[k];
      end
      for (int k = 0; k < SHAMT_W - 1; k++) begin
        shamt_q[k] <= st_shamt[k];
        mode_q[k]  <= st_mode[k];
      end
      zero_q <= st_valid[Last] && (data_d[Last] == '0);
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[Last];
  assign bus.out_data  = data_q[Last];
  assign bus.out_carry = carry_q[Last];
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for the pipelined barrel shifter at WIDTH=8 (directed + exhaustive)
// and WIDTH=16 (random subset).
module tb_pipelined_barrel_shifter;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;  // 0: out_ready=1, 1: out_ready=0, 2: random
  bit   chk_lat = 1'b0;
  exp_t q8[$];
  exp_t q16[$];

  pipelined_barrel_shifter_if #(.WIDTH(8))  b8 ();
  pipelined_barrel_shifter_if #(.WIDTH(16)) b16 ();

  pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  pipelined_barrel_shifter #(.WIDTH(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       begin b8.out_ready = 1'b1; b16.out_ready = 1'b1; end
      1:       begin b8.out_ready = 1'b0; b16.out_ready = 1'b0; end
      default: begin
        b8.out_ready  = 1'($urandom_range(0, 1));
        b16.out_ready = 1'($urandom_range(0, 1));
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model(input int w, input logic [31:0] d, input int s,
                                input logic [1:0] m, output logic [31:0] r, output logic c);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    c = 1'b0;
    case (m)
      2'b00: begin
        r = (d << s) & mask;
        if (s != 0) c = d[w-s];
      end
      2'b01: begin
        r = d >> s;
        if (s != 0) c = d[s-1];
      end
      2'b10: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
        if (s != 0) c = d[s-1];
      end
      default: begin
        r = ((d >> s) | (d << (w - s))) & mask;
        if (s != 0) c = r[w-1];
      end
    endcase
  endfunction

  // Output monitors: a transfer happens at the next edge when valid && ready at the negedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        check_eq("w8 spurious beat", 32'(b8.out_valid), 32'd0);
      end else begin
        e = q8.pop_front();
        check_eq("w8 data", 32'(b8.out_data), 32'(e.data[7:0]));
        check_eq("w8 carry", 32'(b8.out_carry), 32'(e.carry));
        check_eq("w8 zero", 32'(b8.out_zero), 32'(e.data[7:0] == 8'h00));
        if (chk_lat) check_eq("w8 latency", cyc - e.acc, 32'd2);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        check_eq("w16 spurious beat", 32'(b16.out_valid), 32'd0);
      end else begin
        e = q16.pop_front();
        check_eq("w16 data", 32'(b16.out_data), 32'(e.data));
        check_eq("w16 carry", 32'(b16.out_carry), 32'(e.carry));
        check_eq("w16 zero", 32'(b16.out_zero), 32'(e.data == 16'h0000));
      end
    end
  end

  task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                       input logic [7:0] ed, input logic ec);
    exp_t e;
    int   guard;
    b8.in_valid = 1'b1;
    b8.in_data  = d;
    b8.in_shamt = s;
    b8.in_mode  = m;
    guard = 0;
    @(negedge clk);
    while (!b8.in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      check_eq("w8 accept timeout", 32'(b8.in_ready), 32'd1);
    end else begin
      e.data  = {8'h00, ed};
      e.carry = ec;
      e.acc   = cyc + 1;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic send8m(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    logic [31:0] r;
    logic        c;
    model(8, 32'(d), int'(s), m, r, c);
    send8(d, s, m, r[7:0], c);
  endtask

  task automatic send16m(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m);
    exp_t        e;
    int          guard;
    logic [31:0] r;
    logic        c;
    model(16, 32'(d), int'(s), m, r, c);
    b16.in_valid = 1'b1;
    b16.in_data  = d;
    b16.in_shamt = s;
    b16.in_mode  = m;
    guard = 0;
    @(negedge clk);
    while (!b16.in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      check_eq("w16 accept timeout", 32'(b16.in_ready), 32'd1);
    end else begin
      e.data  = r[15:0];
      e.carry = c;
      e.acc   = cyc + 1;
      q16.push_back(e);
    end
    @(posedge clk);
    #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic set_rdy(input int m);
    rdy_mode = m;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q8.size() != 0 || q16.size() != 0) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain leftover beats", 32'(q8.size() + q16.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t head;
    rst = 1'b1;
    b8.in_valid  = 1'b0;
    b8.in_data   = '0;
    b8.in_shamt  = '0;
    b8.in_mode   = '0;
    b16.in_valid = 1'b0;
    b16.in_data  = '0;
    b16.in_shamt = '0;
    b16.in_mode  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset out_valid", 32'(b8.out_valid), 32'd0);
    check_eq("reset out_data", 32'(b8.out_data), 32'd0);
    check_eq("reset out_carry", 32'(b8.out_carry), 32'd0);
    check_eq("reset out_zero", 32'(b8.out_zero), 32'd0);
    check_eq("reset in_ready", 32'(b8.in_ready), 32'd1);
    check_eq("reset w16 out_valid", 32'(b16.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Mode coverage at full rate, with latency checked.
    chk_lat = 1'b1;
    send8(8'hA6, 3'd3, 2'b00, 8'h30, 1'b1);
    send8(8'hA6, 3'd1, 2'b01, 8'h53, 1'b0);
    send8(8'hA6, 3'd4, 2'b10, 8'hFA, 1'b0);
    send8(8'hA6, 3'd2, 2'b11, 8'hA9, 1'b1);
    drain();
    chk_lat = 1'b0;

    // Identity and zero-flag corners.
    for (int m = 0; m < 4; m++) send8(8'hA6, 3'd0, 2'(m), 8'hA6, 1'b0);
    send8(8'h80, 3'd1, 2'b00, 8'h00, 1'b1);
    send8(8'h80, 3'd7, 2'b10, 8'hFF, 1'b0);
    drain();

    // Backpressure: three beats fill the pipe, then hold for five cycles.
    set_rdy(1);
    send8m(8'h5C, 3'd2, 2'b00);
    send8m(8'hC3, 3'd5, 2'b10);
    send8m(8'h81, 3'd7, 2'b11);
    head = q8[0];
    repeat (5) begin
      @(negedge clk);
      check_eq("stall in_ready", 32'(b8.in_ready), 32'd0);
      check_eq("stall out_valid", 32'(b8.out_valid), 32'd1);
      check_eq("stall out_data", 32'(b8.out_data), 32'(head.data[7:0]));
      check_eq("stall out_carry", 32'(b8.out_carry), 32'(head.carry));
    end
    check_eq("stall queue depth", 32'(q8.size()), 32'd3);
    @(posedge clk);
    #1;
    set_rdy(0);
    drain();

    // Bubbles with random downstream readiness.
    set_rdy(2);
    for (int i = 0; i < 40; i++) begin
      send8m(8'($urandom), 3'($urandom), 2'($urandom));
      @(posedge clk);
      #1;
    end
    set_rdy(0);
    drain();

    // Reset while two beats are in flight: both must vanish.
    send8m(8'h3C, 3'd1, 2'b00);
    send8m(8'hF0, 3'd4, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q8.delete();
    q16.delete();
    repeat (6) begin
      @(negedge clk);
      check_eq("flush out_valid", 32'(b8.out_valid), 32'd0);
      check_eq("flush out_data", 32'(b8.out_data), 32'd0);
      check_eq("flush out_carry", 32'(b8.out_carry), 32'd0);
      check_eq("flush out_zero", 32'(b8.out_zero), 32'd0);
    end
    @(posedge clk);
    #1;

    // Exhaustive WIDTH=8 sweep at full rate.
    for (int d = 0; d < 256; d++)
      for (int s = 0; s < 8; s++)
        for (int m = 0; m < 4; m++)
          send8m(8'(d), 3'(s), 2'(m));
    drain();

    // WIDTH=16 random subset, part at full rate and part with random readiness.
    for (int i = 0; i < 300; i++) send16m(16'($urandom), 4'($urandom), 2'($urandom));
    drain();
    set_rdy(2);
    for (int i = 0; i < 200; i++) send16m(16'($urandom), 4'($urandom), 2'($urandom));
    set_rdy(0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter/rotator with a valid/ready handshake on both sides.
- Supports four operating modes: logical left, logical right, arithmetic right and rotate right.
- One pipeline stage per shift-amount bit, so WIDTH=8 gives 3 stages.
- Sits in the datapath library as the general replacement for fixed 4-bit combinational shifters. Reports carry-out and zero flags for downstream ALU use.

Parameters:
- WIDTH, 8: data width in bits; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH): shift-amount width; equals the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out (see below).
- out_zero  output  1  out_data == 0.

Behaviour:
- Reset (synchronous, active-high, clk edge with rst=1):
  - All stage valid bits clear.
  - out_valid=0, out_data=0, out_carry=0, out_zero=0.
  - Beats in flight when reset is asserted mid-operation are discarded. No output beat appears for them.
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, combinational from out_valid/out_ready only. It never depends on in_valid.
  - A beat is accepted on a clk edge where in_valid && in_ready.
- Pipeline:
  - Stage k (k=0..SHAMT_W-1) shifts by 2^k when bit k of the carried shamt is 1. Otherwise the data passes unchanged.
  - Each stage registers data, remaining shamt, mode, carry and valid. All stages load only when adv=1.
  - When adv=0 every stage holds, including empty (bubble) stages. Bubbles are not compressed.
- Latency and throughput:
  - A beat accepted at edge N is presented at out_valid after edge N+SHAMT_W-1. For WIDTH=8 the result is visible 3 edges after acceptance, counting the acceptance edge.
  - Throughput is 1 beat/cycle when out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_carry and out_zero hold stable.
- Mode fill rules:
  - LSL: fill with 0.
  - LSR: fill with 0.
  - ASR: fill with the operand MSB.
  - ROR: bits shifted out of LSB re-enter at MSB.
- Carry rules (per stage that actually shifts; stages that do not shift pass carry through):
  - LSL: carry = stage-input bit[WIDTH-2^k].
  - LSR/ASR: carry = stage-input bit[2^k-1].
  - ROR: out_carry = out_data[WIDTH-1] when total shamt != 0.
  - shamt=0 in any mode: out_carry=0 and out_data=in_data.
- out_zero is computed from the final-stage data and registered with it.
- Shift amount: in_shamt is modulo WIDTH by construction (width SHAMT_W). No illegal amounts exist.
- Simultaneous events:
  - rst has priority over any handshake.
  - Accept and emit may occur on the same edge (full-rate streaming).
- Modes may change per beat. Each beat carries its own mode through the pipeline.

Test Plan (WIDTH=8):
- Mode coverage, back-to-back with out_ready=1, in_data=0xA6:
  - LSL shamt 3 -> out_data=0x30, carry=1, zero=0.
  - LSR 1 -> 0x53, carry=0.
  - ASR 4 -> 0xFA, carry=0.
  - ROR 2 -> 0xA9, carry=1.
  - Results emerge in order on consecutive cycles, each 3 edges after its acceptance.
- Zero/identity cases:
  - in_data=0xA6, shamt 0, each mode -> 0xA6, carry=0.
  - in_data=0x80 LSL 1 -> 0x00, carry=1, zero=1.
  - in_data=0x80 ASR 7 -> 0xFF.
- Backpressure:
  - Fill the pipe with 3 beats, then hold out_ready=0 for 5 cycles -> in_ready=0, out_data stable, no beat lost or duplicated.
  - Release out_ready -> 3 results in order.
- Bubble handling: alternate in_valid 1/0 with out_ready random (seeded) -> output sequence matches a reference model, with no extra or missing beats.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0 on the following cycle and throughout. Neither beat appears afterwards, and outputs read 0.
- Exhaustive sweep: all 256 data values × 8 shamt values × 4 modes, streamed at full rate -> every result and carry matches the model. Also re-run with WIDTH=16 on a random subset.
